// File: rtl/mem_arbiter_pkg.sv
// Shared types and geometry for the memory arbiter: FSM states, requester ids,
// and line/beat sizing for the 64-bit burst pmem interface.
package mem_arbiter_pkg;

    localparam int BURST_LEN = 4;
    localparam int PMEM_W    = 64;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = BURST_LEN * PMEM_W;
    localparam int BEAT_W    = $clog2(BURST_LEN);
    localparam int MBE_W     = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } requester_t;

    // Extract word idx (address bits [4:2]) from a line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [2:0]        idx);
        return line[{idx, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/mem_arbiter_line_merge.sv
// Byte-masked insert of one core word into a cache line; purely combinational.
module line_merge
    import mem_arbiter_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [2:0]        word_idx_i,
    input  logic [MBE_W-1:0]  mbe_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [LINE_W-1:0] line_o
);

    // Replace each enabled byte lane of the selected word.
    always_comb begin
        line_o = line_i;
        for (int b = 0; b < MBE_W; b++) begin
            if (mbe_i[b]) begin
                line_o[int'(word_idx_i) * WORD_W + b * 8 +: 8] = wdata_i[b * 8 +: 8];
            end else begin
                line_o[int'(word_idx_i) * WORD_W + b * 8 +: 8] = line_i[int'(word_idx_i) * WORD_W + b * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data word ports onto a burst pmem interface,
// filling a line buffer per request and writing it back (read-modify-write) for stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_read,
    input  logic [31:0]       instr_mem_address,
    output logic              instr_mem_resp,
    output logic [WORD_W-1:0] instr_mem_rdata,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [MBE_W-1:0]  data_mbe,
    input  logic [31:0]       data_mem_address,
    input  logic [WORD_W-1:0] data_mem_wdata,
    output logic              data_mem_resp,
    output logic [WORD_W-1:0] data_mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [PMEM_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [PMEM_W-1:0] pmem_rdata
);

    arb_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    requester_t        id_q, id_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [MBE_W-1:0]  mbe_q, mbe_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              instr_resp_q, instr_resp_d;
    logic              data_resp_q, data_resp_d;
    logic [WORD_W-1:0] instr_rdata_q, instr_rdata_d;
    logic [WORD_W-1:0] data_rdata_q, data_rdata_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [31:0]       pmem_addr_q, pmem_addr_d;
    logic [PMEM_W-1:0] pmem_wdata_q, pmem_wdata_d;

    logic [LINE_W-1:0] buf_fill_s;
    logic [LINE_W-1:0] merged_s;
    logic              last_beat_s;
    logic [WORD_W-1:0] resp_word_s;

    // Buffer as it looks once the current read beat has landed.
    always_comb begin
        buf_fill_s = buf_q;
        buf_fill_s[{beat_q, 6'b000000} +: PMEM_W] = pmem_rdata;
    end

    // The store merge sees the final read beat, so the written line is complete.
    line_merge u_line_merge (
        .line_i     (buf_fill_s),
        .word_idx_i (addr_q[4:2]),
        .mbe_i      (mbe_q),
        .wdata_i    (wdata_q),
        .line_o     (merged_s)
    );

    assign last_beat_s = (beat_q == BEAT_W'(BURST_LEN - 1));

    // Next-state, beat counter, buffer and request holding registers.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        mbe_d   = mbe_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (data_write || data_read) begin
                    id_d    = REQ_DATA;
                    wr_d    = data_write;
                    addr_d  = data_mem_address;
                    mbe_d   = data_mbe;
                    wdata_d = data_mem_wdata;
                    state_d = RD_BURST;
                end else if (instr_read) begin
                    id_d    = REQ_INSTR;
                    wr_d    = 1'b0;
                    addr_d  = instr_mem_address;
                    mbe_d   = {MBE_W{1'b0}};
                    wdata_d = {WORD_W{1'b0}};
                    state_d = RD_BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                if (pmem_resp) begin
                    buf_d = buf_fill_s;
                    if (last_beat_s) begin
                        beat_d = {BEAT_W{1'b0}};
                        if (wr_q) begin
                            buf_d   = merged_s;
                            state_d = WR_BURST;
                        end else begin
                            state_d = RESP;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (pmem_resp) begin
                    if (last_beat_s) begin
                        beat_d  = {BEAT_W{1'b0}};
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                beat_d  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from next state so they come straight out of flops.
    always_comb begin
        resp_word_s   = line_word(buf_d, addr_d[4:2]);
        pmem_read_d   = (state_d == RD_BURST);
        pmem_write_d  = (state_d == WR_BURST);
        pmem_addr_d   = {addr_d[31:5], 5'b00000};
        instr_resp_d  = (state_d == RESP) && (id_d == REQ_INSTR);
        data_resp_d   = (state_d == RESP) && (id_d == REQ_DATA);
        instr_rdata_d = instr_resp_d ? resp_word_s : {WORD_W{1'b0}};
        data_rdata_d  = data_resp_d ? resp_word_s : {WORD_W{1'b0}};
        if (state_d == WR_BURST) begin
            pmem_wdata_d = buf_d[{beat_d, 6'b000000} +: PMEM_W];
        end else begin
            pmem_wdata_d = {PMEM_W{1'b0}};
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= {BEAT_W{1'b0}};
            buf_q         <= {LINE_W{1'b0}};
            id_q          <= REQ_INSTR;
            wr_q          <= 1'b0;
            addr_q        <= 32'h0000_0000;
            mbe_q         <= {MBE_W{1'b0}};
            wdata_q       <= {WORD_W{1'b0}};
            instr_resp_q  <= 1'b0;
            data_resp_q   <= 1'b0;
            instr_rdata_q <= {WORD_W{1'b0}};
            data_rdata_q  <= {WORD_W{1'b0}};
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            pmem_addr_q   <= 32'h0000_0000;
            pmem_wdata_q  <= {PMEM_W{1'b0}};
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            buf_q         <= buf_d;
            id_q          <= id_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            mbe_q         <= mbe_d;
            wdata_q       <= wdata_d;
            instr_resp_q  <= instr_resp_d;
            data_resp_q   <= data_resp_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            pmem_read_q   <= pmem_read_d;
            pmem_write_q  <= pmem_write_d;
            pmem_addr_q   <= pmem_addr_d;
            pmem_wdata_q  <= pmem_wdata_d;
        end
    end

    assign instr_mem_resp  = instr_resp_q;
    assign instr_mem_rdata = instr_rdata_q;
    assign data_mem_resp   = data_resp_q;
    assign data_mem_rdata  = data_rdata_q;
    assign pmem_read       = pmem_read_q;
    assign pmem_write      = pmem_write_q;
    assign pmem_address    = pmem_addr_q;
    assign pmem_wdata      = pmem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a pmem memory model plus a transaction-level reference
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    mem_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_mbe          (data_mbe),
        .data_mem_address  (data_mem_address),
        .data_mem_wdata    (data_mem_wdata),
        .data_mem_resp     (data_mem_resp),
        .data_mem_rdata    (data_mem_rdata),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_resp         (pmem_resp),
        .pmem_rdata        (pmem_rdata)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // pmem contents, keyed by line number (address >> 5)
    logic [255:0] pmem [int unsigned];
    bit           stall_mode = 1'b0;
    bit           pat [$];
    int           pm_rd = 0;
    int           pm_wr = 0;
    logic [255:0] pm_wbuf;

    function automatic logic [255:0] get_line(input logic [31:0] a);
        int unsigned k = a >> 5;
        if (!pmem.exists(k)) pmem[k] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                        $urandom(), $urandom(), $urandom(), $urandom()};
        return pmem[k];
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] l, input logic [31:0] a,
                                           input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) l[int'(a[4:2]) * 32 + b * 8 +: 8] = wd[b * 8 +: 8];
        return l;
    endfunction

    // pmem responder: drives resp/rdata shortly after each rising edge
    initial begin
        logic [255:0] ln;
        pmem_resp  = 1'b0;
        pmem_rdata = 64'h0;
        forever begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                if (pat.size() > 0) pmem_resp = pat.pop_front();
                else if (stall_mode) pmem_resp = ($urandom_range(0, 9) < 7);
                else pmem_resp = 1'b1;
            end else begin
                pmem_resp = 1'b0;
            end
            if (pmem_read) begin
                ln = get_line(pmem_address);
                pmem_rdata = ln[pm_rd * 64 +: 64];
            end else begin
                pmem_rdata = {$urandom(), $urandom()};
            end
        end
    end

    // Reference: one transaction at a time, data before instr, grant in an idle cycle,
    // 4 accepted read beats, 4 accepted write beats for stores, then a single resp cycle.
    bit           m_busy = 0, m_resp_due = 0, m_store = 0, m_owner_data = 0;
    logic [31:0]  m_addr;
    logic [255:0] m_line;
    int           m_rd = 0, m_wr = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outputs", {instr_mem_resp, data_mem_resp, pmem_read, pmem_write},  4'b0000);
            chk("rst_values", {instr_mem_rdata, data_mem_rdata, pmem_address, pmem_wdata}, 160'h0);
            m_busy = 0; m_resp_due = 0; pm_rd = 0; pm_wr = 0;
        end else begin
            if (m_resp_due) begin
                chk("m_resp_port", {instr_mem_resp, data_mem_resp}, m_owner_data ? 2'b01 : 2'b10);
                chk("m_resp_pmem", {pmem_read, pmem_write}, 2'b00);
                if (m_owner_data) chk("m_data_rdata", data_mem_rdata, m_line[int'(m_addr[4:2]) * 32 +: 32]);
                else chk("m_instr_rdata", instr_mem_rdata, m_line[int'(m_addr[4:2]) * 32 +: 32]);
                m_resp_due = 0;
                m_busy = 0;
            end else if (m_busy) begin
                chk("m_busy_resp", {instr_mem_resp, data_mem_resp}, 2'b00);
                chk("m_pmem_address", pmem_address, {m_addr[31:5], 5'b00000});
                if (m_rd < 4) begin
                    chk("m_rd_phase", {pmem_read, pmem_write}, 2'b10);
                    if (pmem_resp) begin
                        m_rd++;
                        if (m_rd == 4 && !m_store) m_resp_due = 1;
                    end
                end else begin
                    chk("m_wr_phase", {pmem_read, pmem_write}, 2'b01);
                    chk("m_wdata", pmem_wdata, m_line[m_wr * 64 +: 64]);
                    if (pmem_resp) begin
                        m_wr++;
                        if (m_wr == 4) m_resp_due = 1;
                    end
                end
            end else begin
                chk("m_idle", {instr_mem_resp, data_mem_resp, pmem_read, pmem_write}, 4'b0000);
                if (data_write || data_read || instr_read) begin
                    m_busy       = 1;
                    m_owner_data = data_write || data_read;
                    m_store      = data_write;
                    m_addr       = m_owner_data ? data_mem_address : instr_mem_address;
                    m_line       = get_line(m_addr);
                    if (m_store) m_line = merge(m_line, m_addr, data_mbe, data_mem_wdata);
                    m_rd = 0;
                    m_wr = 0;
                end
            end
            if (pmem_read && pmem_resp) pm_rd = (pm_rd + 1) % 4;
            if (pmem_write && pmem_resp) begin
                pm_wbuf[pm_wr * 64 +: 64] = pmem_wdata;
                pm_wr++;
                if (pm_wr == 4) begin
                    pmem[pmem_address >> 5] = pm_wbuf;
                    pm_wr = 0;
                end
            end
        end
    end

    task automatic do_req(input bit is_data, input bit wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic [31:0] pa, output logic [63:0] wb0);
        bit seen_r = 0, seen_w = 0;
        rd = 32'h0; pa = 32'h0; wb0 = 64'h0;
        @(posedge clk); #1;
        if (is_data) begin
            data_write = wr; data_read = !wr; data_mem_address = a;
            data_mbe = be; data_mem_wdata = wd;
        end else begin
            instr_read = 1'b1; instr_mem_address = a;
        end
        lat = 1;
        while (lat < 100) begin
            if (pmem_read && !seen_r) begin seen_r = 1; pa = pmem_address; end
            if (pmem_write && !seen_w) begin seen_w = 1; wb0 = pmem_wdata; end
            if (is_data ? data_mem_resp : instr_mem_resp) begin
                rd = is_data ? data_mem_rdata : instr_mem_rdata;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    endtask

    initial begin
        int           lat, cyc, ic, dc;
        logic [31:0]  rd, pa, ir, dr;
        logic [63:0]  wb0;
        logic [255:0] l5;

        rst_n = 1'b0;
        instr_read = 1'b0; instr_mem_address = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
        data_mem_address = 32'h0; data_mem_wdata = 32'h0;
        repeat (3) @(posedge clk); #1;
        chk("reset_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        chk("reset_resp", {instr_mem_resp, data_mem_resp}, 2'b00);
        rst_n = 1'b1;

        // fetch: word 1 of the line is the upper half of beat 0
        pmem[32'h64 >> 5] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_req(1'b0, 1'b0, 32'h0000_0064, 4'h0, 32'h0, lat, rd, pa, wb0);
        chk("t1_latency", lat, 6);
        chk("t1_rdata", rd, 32'h1111_1111);
        chk("t1_pmem_address", pa, 32'h0000_0060);

        // store one byte into an all-ones line
        pmem[32'h104 >> 5] = {256{1'b1}};
        do_req(1'b1, 1'b1, 32'h0000_0104, 4'b0010, 32'h0000_AB00, lat, rd, pa, wb0);
        chk("t2_latency", lat, 10);
        chk("t2_rdata", rd, 32'hFFFF_ABFF);
        chk("t2_beat0", wb0, 64'hFFFF_ABFF_FFFF_FFFF);
        chk("t2_line", pmem[32'h104 >> 5], {{192{1'b1}}, 64'hFFFF_ABFF_FFFF_FFFF});

        // contention: data first, instr granted the cycle after data resp
        pmem[32'h40 >> 5] = {192'h0, 64'h0BAD_F00D_1234_5678};
        pmem[32'h88 >> 5] = {128'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0};
        @(posedge clk); #1;
        instr_read = 1'b1; instr_mem_address = 32'h0000_0040;
        data_read = 1'b1; data_mem_address = 32'h0000_0088;
        cyc = 1; ic = 0; dc = 0; ir = 32'h0; dr = 32'h0;
        while (cyc < 100) begin
            if (data_mem_resp && dc == 0) begin dc = cyc; dr = data_mem_rdata; data_read = 1'b0; end
            if (instr_mem_resp && ic == 0) begin ic = cyc; ir = instr_mem_rdata; instr_read = 1'b0; end
            if (ic != 0 && dc != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        instr_read = 1'b0; data_read = 1'b0;
        chk("t3_data_cycle", dc, 6);
        chk("t3_instr_cycle", ic, 12);
        chk("t3_data_rdata", dr, 32'hCCCC_DDDD);
        chk("t3_instr_rdata", ir, 32'h1234_5678);

        // stalled read burst: 7 read cycles, 4 accepted beats
        pmem[32'h208 >> 5] = {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000,
                              64'h5555_6666_7777_8888, 64'h1111_0000_1111_0000};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_req(1'b1, 1'b0, 32'h0000_0208, 4'h0, 32'h0, lat, rd, pa, wb0);
        chk("t4_latency", lat, 9);
        chk("t4_rdata", rd, 32'h7777_8888);

        // reset during the write burst, after beat 1 was accepted
        l5 = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
              64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_5A5A_5A5A};
        pmem[32'h304 >> 5] = l5;
        @(posedge clk); #1;
        data_write = 1'b1; data_mem_address = 32'h0000_0304;
        data_mbe = 4'hF; data_mem_wdata = 32'h1234_5678;
        repeat (7) @(posedge clk); #1;
        chk("t5_in_write", pmem_write, 1'b1);
        rst_n = 1'b0;
        data_write = 1'b0;
        #1;
        chk("t5_write_dropped", {pmem_read, pmem_write, data_mem_resp}, 3'b000);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 32'h0000_0304, 4'h0, 32'h0, lat, rd, pa, wb0);
        chk("t5_reload_latency", lat, 6);
        chk("t5_reload_rdata", rd, 32'hA0A0_A0A0);
        chk("t5_line_untouched", pmem[32'h304 >> 5], l5);

        // load word 7: upper half of beat 3
        pmem[0] = {64'hDEAD_BEEF_CAFE_F00D, 192'h0};
        do_req(1'b1, 1'b0, 32'h0000_001C, 4'h0, 32'h0, lat, rd, pa, wb0);
        chk("t6_rdata", rd, 32'hDEAD_BEEF);

        // random traffic on a few shared lines with a stalling pmem
        stall_mode = 1'b1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int t;
                    repeat ($urandom_range(1, 3)) @(posedge clk); #1;
                    instr_read = 1'b1;
                    instr_mem_address = 32'h0000_1000 | ($urandom_range(0, 255) & 32'hFFFF_FFFC);
                    t = 0;
                    while (!instr_mem_resp && t < 300) begin @(posedge clk); #1; t++; end
                    chk("rand_instr_done", (t < 300), 1'b1);
                    instr_read = 1'b0;
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    int t;
                    bit w;
                    repeat ($urandom_range(1, 3)) @(posedge clk); #1;
                    w = $urandom_range(0, 1);
                    data_write = w;
                    data_read = w ? ($urandom_range(0, 3) == 0) : 1'b1;
                    data_mem_address = 32'h0000_1000 | ($urandom_range(0, 255) & 32'hFFFF_FFFC);
                    data_mbe = 4'($urandom());
                    data_mem_wdata = $urandom();
                    t = 0;
                    while (!data_mem_resp && t < 300) begin @(posedge clk); #1; t++; end
                    chk("rand_data_done", (t < 300), 1'b1);
                    data_write = 1'b0; data_read = 1'b0;
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
